// File: rtl/fifo_ptr_sync_level.sv
// Read-side write-pointer synchronizer with fill-level, flag and error logic.
// Ports:
//   R_CLK, R_rst      : read clock, synchronous active-high reset
//   W_ptr             : Gray write pointer (asynchronous to R_CLK)
//   R_rptr_bin        : binary read pointer (R_CLK domain)
//   err_clr           : clears sticky error flags (a set condition wins)
//   Rq_wptr_gray/bin  : synchronized write pointer, Gray and binary
//   ptr_chg           : one-cycle pulse per synchronized pointer change
//   level, empty, full, almost_empty : registered fill level and flags
//   sync_valid        : chain warmed up after reset
//   err_gray, err_level : sticky illegal-transition / impossible-level flags
module fifo_ptr_sync_level #(
   parameter int ADDR_FIFO   = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 2
) (
   input  logic                 R_CLK,
   input  logic                 R_rst,
   input  logic [ADDR_FIFO:0]   W_ptr,
   input  logic [ADDR_FIFO:0]   R_rptr_bin,
   input  logic                 err_clr,
   output logic [ADDR_FIFO:0]   Rq_wptr_gray,
   output logic [ADDR_FIFO:0]   Rq_wptr_bin,
   output logic                 ptr_chg,
   output logic [ADDR_FIFO:0]   level,
   output logic                 empty,
   output logic                 full,
   output logic                 almost_empty,
   output logic                 sync_valid,
   output logic                 err_gray,
   output logic                 err_level
);

   localparam int PW = ADDR_FIFO + 1;
   localparam logic [PW-1:0] LP_DEPTH = {1'b1, {ADDR_FIFO{1'b0}}};
   localparam logic [PW-1:0] LP_AE    = PW'(AE_THRESH);
   localparam logic [2:0]    LP_WMAX  = 3'(SYNC_STAGES + 1);
   localparam logic [2:0]    LP_WLAST = 3'(SYNC_STAGES);

   logic [PW-1:0] r_stage [SYNC_STAGES];
   logic [PW-1:0] r_prev;
   logic [2:0]    r_wcnt;
   logic          r_sync_valid;
   logic          r_ptr_chg;
   logic [PW-1:0] r_level;
   logic          r_empty;
   logic          r_full;
   logic          r_ae;
   logic          r_err_gray;
   logic          r_err_level;

   logic [PW-1:0] w_gray;
   logic [PW-1:0] w_bin;
   logic [PW-1:0] w_diff;
   logic [PW-1:0] w_raw;
   logic          w_multi;
   logic          w_lvl_bad;

   assign w_gray = r_stage[SYNC_STAGES-1];
   assign w_diff = w_gray ^ r_prev;

   // A nonzero diff with more than one set bit: clearing the lowest set
   // bit still leaves something behind.
   assign w_multi = (w_diff & (w_diff - PW'(1))) != '0;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < PW; i++) begin
         w_bin[i] = ^(w_gray >> i);
      end
   end

   // Modulo subtraction; the extra MSB separates full from empty.
   assign w_raw     = w_bin - R_rptr_bin;
   assign w_lvl_bad = w_raw > LP_DEPTH;

   always_ff @(posedge R_CLK) begin
      if (R_rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_stage[k] <= '0;
         end
         r_prev       <= '0;
         r_wcnt       <= '0;
         r_sync_valid <= 1'b0;
         r_ptr_chg    <= 1'b0;
         r_level      <= '0;
         r_empty      <= 1'b1;
         r_full       <= 1'b0;
         r_ae         <= 1'b1;
         r_err_gray   <= 1'b0;
         r_err_level  <= 1'b0;
      end else begin
         r_stage[0] <= W_ptr;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
         end
         r_prev <= w_gray;
         if (r_wcnt != LP_WMAX) begin
            r_wcnt <= r_wcnt + 3'd1;
         end
         // Valid from the edge after the chain has been fully refilled.
         if (r_wcnt == LP_WLAST) begin
            r_sync_valid <= 1'b1;
         end
         r_ptr_chg <= (w_diff != '0) && r_sync_valid;
         r_level   <= w_raw;
         r_empty   <= (w_raw == '0);
         r_full    <= (w_raw == LP_DEPTH);
         r_ae      <= (w_raw <= LP_AE);
         if (r_sync_valid && w_multi) begin
            r_err_gray <= 1'b1;
         end else if (err_clr) begin
            r_err_gray <= 1'b0;
         end
         if (r_sync_valid && w_lvl_bad) begin
            r_err_level <= 1'b1;
         end else if (err_clr) begin
            r_err_level <= 1'b0;
         end
      end
   end

   assign Rq_wptr_gray = w_gray;
   assign Rq_wptr_bin  = w_bin;
   assign ptr_chg      = r_ptr_chg;
   assign level        = r_level;
   assign empty        = r_empty;
   assign full         = r_full;
   assign almost_empty = r_ae;
   assign sync_valid   = r_sync_valid;
   assign err_gray     = r_err_gray;
   assign err_level    = r_err_level;

endmodule
